reset_seq: RTL

// - Downstream consumer of the testbench/system power-on reset. Holds all N reset domains

---
 rtl/reset_seq_pkg.sv | 13 +
 rtl/reset_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and counter width.
package reset_seq_pkg;

    localparam int unsigned RS_COUNT_W = 32;

    typedef enum logic [1:0] {
        RS_ASSERT,
        RS_RELEASE,
        RS_GAP,
        RS_DONE
    } reset_seq_state_e;

endpackage

// File: rtl/reset_seq.sv
// Reset sequencer: holds all domains in reset, then releases them one by one in index
// order, waiting for each domain's ready (or a timeout) plus a fixed gap in between.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned N_DOMAINS   = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 soft_req,
    input  logic [N_DOMAINS-1:0] domain_ready,
    output logic [N_DOMAINS-1:0] domain_reset,
    output logic                 all_released,
    output logic [N_DOMAINS-1:0] timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_DOMAINS) + 1;

    localparam logic [RS_COUNT_W-1:0] HOLD_LAST = RS_COUNT_W'(HOLD_CYCLES - 1);
    localparam logic [RS_COUNT_W-1:0] GAP_LAST  = RS_COUNT_W'(GAP_CYCLES - 1);
    localparam logic [RS_COUNT_W-1:0] TO_LAST   = RS_COUNT_W'(TIMEOUT - 1);
    localparam bit                    TO_EN     = (TIMEOUT != 0);

    if (N_DOMAINS < 1 || N_DOMAINS > 16 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
        $error("reset_seq: N_DOMAINS must be 1..16, HOLD_CYCLES and GAP_CYCLES >= 1");
    end

    reset_seq_state_e        state, state_d;
    logic [RS_COUNT_W-1:0]   count, count_d;
    logic [IDX_W-1:0]        idx, idx_d, idx_next;
    logic [N_DOMAINS-1:0]    dr_d, to_d;
    logic                    all_d;
    logic                    ready_cur;
    logic                    timed_out;

    always_comb begin
        state_d   = state;
        count_d   = count;
        idx_d     = idx;
        dr_d      = domain_reset;
        to_d      = timeout_err;
        all_d     = all_released;
        ready_cur = 1'b0;
        idx_next  = idx + IDX_W'(1);

        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
            if (idx == IDX_W'(k)) begin
                ready_cur = domain_ready[k];
            end
        end
        timed_out = TO_EN && (count == TO_LAST);

        // A soft request outside ASSERT restarts everything; it outranks ready/timeout/gap.
        if (soft_req && state != RS_ASSERT) begin
            state_d = RS_ASSERT;
            count_d = '0;
            idx_d   = '0;
            dr_d    = '1;
            to_d    = '0;
            all_d   = 1'b0;
        end else begin
            unique case (state)
                RS_ASSERT: begin
                    if (soft_req) begin
                        count_d = '0;
                    end else if (count == HOLD_LAST) begin
                        dr_d[0] = 1'b0;
                        idx_d   = '0;
                        count_d = '0;
                        state_d = RS_RELEASE;
                    end else begin
                        count_d = count + RS_COUNT_W'(1);
                    end
                end

                RS_RELEASE: begin
                    count_d = count + RS_COUNT_W'(1);
                    if (ready_cur || timed_out) begin
                        if (!ready_cur) begin
                            for (int unsigned k = 0; k < N_DOMAINS; k++) begin
                                if (idx == IDX_W'(k)) begin
                                    to_d[k] = 1'b1;
                                end
                            end
                        end
                        if (idx == IDX_W'(N_DOMAINS - 1)) begin
                            all_d   = 1'b1;
                            state_d = RS_DONE;
                        end else begin
                            count_d = '0;
                            state_d = RS_GAP;
                        end
                    end
                end

                RS_GAP: begin
                    count_d = count + RS_COUNT_W'(1);
                    if (count == GAP_LAST) begin
                        idx_d   = idx_next;
                        count_d = '0;
                        state_d = RS_RELEASE;
                        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
                            if (idx_next == IDX_W'(k)) begin
                                dr_d[k] = 1'b0;
                            end
                        end
                    end
                end

                RS_DONE: begin
                end

                default: begin
                    state_d = RS_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= RS_ASSERT;
            count        <= '0;
            idx          <= '0;
            domain_reset <= '1;
            timeout_err  <= '0;
            all_released <= 1'b0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            idx          <= idx_d;
            domain_reset <= dr_d;
            timeout_err  <= to_d;
            all_released <= all_d;
        end
    end

endmodule
